icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 164 ++++++++++++++++
 tb/tb_icache_refill.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
//
// Instruction-cache line refill engine. When the cache reports a miss, the
// block latches the line-aligned base address, reads the line from main
// memory one 32-bit word at a time (word 0 first), assembles the words into
// a full line and pulses fill for one cycle so the cache can write the line.
//
// Parameters
//   WORDS      number of 32-bit words per cache line (power of two, >= 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   miss       refill request from the cache (held until fill is seen)
//   miss_addr  byte address of the missing fetch
//   mem_req    word read request to main memory (high throughout FETCH)
//   mem_addr   byte address of the word currently requested
//   mem_ack    memory accepted the request, mem_rdata valid this cycle
//   mem_rdata  read data from memory
//   dataline   assembled line, word 0 in bits [31:0]
//   line_addr  line-aligned base address of dataline
//   fill       one-cycle pulse: cache writes dataline/line_addr
//   busy       high whenever a refill is in progress (state not IDLE)
// -----------------------------------------------------------------------------
module icache_refill #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss,
  input  logic [31:0]           miss_addr,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [32*WORDS-1:0]   dataline,
  output logic [31:0]           line_addr,
  output logic                  fill,
  output logic                  busy
);

  // Width of the word counter and the mask that clears the in-line offset.
  localparam int          CW        = $clog2(WORDS);
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [32*WORDS-1:0]   r_line;
  logic [31:0]           r_line_addr;

  logic                  w_accept;
  logic                  w_word_ack;
  logic                  w_last_word;
  logic [31:0]           w_word_off;

  // The counter indexes words; the byte offset is simply counter * 4.
  assign w_last_word = (r_cnt == CW'(WORDS - 1));
  assign w_word_off  = {{(30 - CW){1'b0}}, r_cnt, 2'b00};

  // Next-state logic plus the accept / word-ack strobes for the datapath.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_word_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss) begin
          w_next_state = FETCH;
          w_accept     = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      FETCH: begin
        // mem_ack outside FETCH never reaches here, so it is ignored there.
        if (mem_ack) begin
          w_word_ack = 1'b1;
          if (w_last_word) begin
            w_next_state = DONE;
          end else begin
            w_next_state = FETCH;
          end
        end else begin
          w_next_state = FETCH;
        end
      end
      DONE: begin
        // Unconditional return; a miss still held high is taken from IDLE.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register; reset wins over miss and mem_ack on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Line address, word counter and line assembly buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_line      <= '0;
      r_line_addr <= 32'd0;
    end else begin
      if (w_accept) begin
        r_line_addr <= miss_addr & LINE_MASK;
        r_cnt       <= '0;
      end else if (w_word_ack) begin
        // Only the addressed word lane is written; all other bits hold.
        r_line[32*r_cnt +: 32] <= mem_rdata;
        if (!w_last_word) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Memory request and handshake outputs decoded from registered state.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = 32'd0;
    fill     = 1'b0;
    busy     = 1'b0;
    if (r_state == FETCH) begin
      mem_req  = 1'b1;
      mem_addr = r_line_addr + w_word_off;
    end else begin
      mem_req  = 1'b0;
      mem_addr = 32'd0;
    end
    if (r_state == DONE) begin
      fill = 1'b1;
    end else begin
      fill = 1'b0;
    end
    if (r_state != IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // The line buffer and base address stay stable from DONE until the next
  // accepted miss because they only change on accept or word-ack.
  assign dataline  = r_line;
  assign line_addr = r_line_addr;

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
//
// Self-checking bench for icache_refill (WORDS = 4). Directed scenarios are
// followed by randomized refills (random addresses, data, wait states, miss
// toggling, back-to-back misses, idle acks and mid-refill resets). Expected
// values come from a line-level reference model: an expected line image,
// the aligned base address (addr - addr % line_bytes) and the fill cycle
// (one cycle after the last accepted word, plus wait cycles).
// -----------------------------------------------------------------------------
module tb_icache_refill;

  localparam int WORDS = 4;
  localparam int LB    = WORDS * 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                miss;
  logic [31:0]         miss_addr;
  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_ack;
  logic [31:0]         mem_rdata;
  logic [32*WORDS-1:0] dataline;
  logic [31:0]         line_addr;
  logic                fill;
  logic                busy;

  icache_refill #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .miss      (miss),
    .miss_addr (miss_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dataline  (dataline),
    .line_addr (line_addr),
    .fill      (fill),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int fill_cnt = 0;

  // Reference model state.
  logic [127:0] exp_line;
  logic [31:0]  exp_la;
  logic [31:0]  t_data [WORDS];
  int           t_wait [WORDS];

  // Free-running edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count fill pulses, sampled mid-cycle.
  always @(negedge clk) if (fill === 1'b1) fill_cnt <= fill_cnt + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    check_eq({tag, "_busy"},  128'(busy),      128'(1'b0));
    check_eq({tag, "_req"},   128'(mem_req),   128'(1'b0));
    check_eq({tag, "_fill"},  128'(fill),      128'(1'b0));
    check_eq({tag, "_line"},  128'(dataline),  exp_line);
    check_eq({tag, "_laddr"}, 128'(line_addr), 128'(exp_la));
  endtask

  // One refill transaction driven from IDLE. abort_at >= 0 asserts reset in
  // place of that word's ack. chain keeps miss high into the IDLE cycle.
  task automatic refill(input logic [31:0] addr, input bit toggle, input bit chain,
                        input logic [31:0] next_addr, input int abort_at);
    int          acc;
    int          tw;
    int          f0;
    logic [31:0] base;
    tw   = 0;
    f0   = fill_cnt;
    base = addr - (addr % 32'(LB));
    miss = 1'b1; miss_addr = addr; mem_ack = 1'b0;
    step;
    acc    = cyc;
    exp_la = base;
    check_eq("acc_busy",  128'(busy),      128'(1'b1));
    check_eq("acc_laddr", 128'(line_addr), 128'(base));
    for (int w = 0; w < WORDS; w++) begin
      if (w == abort_at) begin
        reset = 1'b1; mem_ack = 1'b1; miss = 1'b1; mem_rdata = $urandom;
        step;
        reset = 1'b0; mem_ack = 1'b0; miss = 1'b0;
        exp_line = 128'd0; exp_la = 32'd0;
        idle_checks("rst");
        return;
      end
      for (int k = 0; k < t_wait[w]; k++) begin
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (toggle) begin miss = 1'($urandom); miss_addr = $urandom; end
        check_eq("wait_req",  128'(mem_req),  128'(1'b1));
        check_eq("wait_addr", 128'(mem_addr), 128'(base + 32'(4 * w)));
        check_eq("wait_fill", 128'(fill),     128'(1'b0));
        check_eq("wait_line", 128'(dataline), exp_line);
        step;
        tw++;
      end
      mem_ack = 1'b1; mem_rdata = t_data[w];
      if (toggle) begin miss = 1'($urandom); miss_addr = $urandom; end
      check_eq("ftch_req",   128'(mem_req),   128'(1'b1));
      check_eq("ftch_addr",  128'(mem_addr),  128'(base + 32'(4 * w)));
      check_eq("ftch_fill",  128'(fill),      128'(1'b0));
      check_eq("ftch_line",  128'(dataline),  exp_line);
      check_eq("ftch_laddr", 128'(line_addr), 128'(base));
      step;
      exp_line[32*w +: 32] = t_data[w];
    end
    // DONE cycle: acks and misses here must be ignored.
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    if (chain) begin
      miss = 1'b1; miss_addr = next_addr;
    end else if (toggle) begin
      miss = 1'($urandom); miss_addr = $urandom;
    end
    check_eq("done_fill",  128'(fill),      128'(1'b1));
    check_eq("done_req",   128'(mem_req),   128'(1'b0));
    check_eq("done_busy",  128'(busy),      128'(1'b1));
    check_eq("done_line",  128'(dataline),  exp_line);
    check_eq("done_laddr", 128'(line_addr), 128'(base));
    // Edge at which the cache samples fill, counted from the accepting edge.
    check_eq("fill_lat",   128'(cyc - acc + 1), 128'(WORDS + 1 + tw));
    step;
    mem_ack = 1'b0;
    if (!chain) miss = 1'b0;
    idle_checks("post");
    check_eq("fill_pulses", 128'(fill_cnt - f0), 128'(1));
  endtask

  // mem_ack pulses while idle must not disturb anything.
  task automatic idle_acks(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      step;
      idle_checks("idleack");
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] nxt;
    bit          chained;
    int          ab;
    reset = 1'b1; miss = 1'b0; miss_addr = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    exp_line = 128'd0; exp_la = 32'd0;
    for (int i = 0; i < WORDS; i++) t_wait[i] = 0;
    step; step; step;
    reset = 1'b0;
    idle_checks("reset");

    // Ack while idle, then a refill must still begin at word 0.
    idle_acks(3);

    // Basic refill at address 0 with zero-wait acks.
    t_data[0] = 32'ha3a2a1a0; t_data[1] = 32'ha7a6a5a4;
    t_data[2] = 32'habaaa9a8; t_data[3] = 32'hafaeadac;
    refill(32'h0000_0000, 1'b0, 1'b0, 32'd0, -1);
    check_eq("line_basic", 128'(dataline), 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0);

    // Unaligned miss address.
    for (int i = 0; i < WORDS; i++) t_data[i] = $urandom;
    refill(32'h0000_1234, 1'b0, 1'b0, 32'd0, -1);
    check_eq("laddr_1234", 128'(line_addr), 128'(32'h0000_1230));

    // Three wait cycles before word 2.
    for (int i = 0; i < WORDS; i++) t_data[i] = $urandom;
    t_wait[2] = 3;
    refill(32'h0000_0000, 1'b0, 1'b0, 32'd0, -1);
    t_wait[2] = 0;

    // Reset after two acks, then a clean restart.
    for (int i = 0; i < WORDS; i++) t_data[i] = $urandom;
    refill(32'h0000_0040, 1'b0, 1'b0, 32'd0, 2);
    refill(32'h0000_0040, 1'b0, 1'b0, 32'd0, -1);

    // Miss toggling during FETCH/DONE, held after fill to chain a second refill.
    for (int i = 0; i < WORDS; i++) t_data[i] = $urandom;
    refill(32'h0000_2000, 1'b1, 1'b1, 32'h0000_3008, -1);
    for (int i = 0; i < WORDS; i++) t_data[i] = $urandom;
    refill(32'h0000_3008, 1'b0, 1'b0, 32'd0, -1);

    // Randomized refills.
    chained = 1'b0;
    nxt = $urandom;
    for (int r = 0; r < 30; r++) begin
      addr = nxt;
      nxt  = $urandom;
      for (int i = 0; i < WORDS; i++) begin
        t_data[i] = $urandom;
        t_wait[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      if (!chained && $urandom_range(0, 3) == 0) idle_acks(2);
      chained = (ab < 0) && ($urandom_range(0, 1) == 1);
      refill(addr, 1'($urandom), chained, nxt, ab);
    end
    if (chained) begin
      for (int i = 0; i < WORDS; i++) begin t_data[i] = $urandom; t_wait[i] = 0; end
      refill(nxt, 1'b0, 1'b0, 32'd0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
